ms_section_master: RTL

- Parametrised successor of the single-channel section-based master/slave test block.
- Section FSM holds a value register and tries a load from a blocking input port.
- It then writes the value round-robin to NUM_CH blocking output channels using DeSCAM-style notify/sync handshakes.
- s_out mirrors the last value the slave side accepted. Used as a property-generation test vehicle.

---
 rtl/ms_section_master_pkg.sv | 18 +
 rtl/ms_section_master_rr_ptr.sv | 33 +++
 rtl/ms_section_master.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/ms_section_master_pkg.sv
// Shared types and defaults for the section-based master: section encoding,
// reset/step defaults and the channel-pointer width helper.
package ms_section_types;

  typedef enum logic {
    SECTION_A,
    SECTION_B
  } Sections;

  localparam int INIT_VAL_DEF = 1337;
  localparam int STEP_DEF     = 1;

  // A single channel still needs one pointer bit so the port has a width.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ms_section_master_rr_ptr.sv
// Round-robin channel pointer: wraps from NUM_CH-1 back to 0 on advance,
// asynchronously cleared to 0 by rst.
module ms_rr_ptr #(
  parameter int NUM_CH = 2,
  parameter int CH_W   = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            advance,
  output logic [CH_W-1:0] ptr
);

  logic [CH_W-1:0] ptr_q;
  logic [CH_W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (ptr_q == CH_W'(NUM_CH - 1)) ? '0 : ptr_q + CH_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/ms_section_master.sv
// Section-based master: try-read one value in SECTION_A, then write it round-robin
// to NUM_CH blocking channels in SECTION_B. Optional wait limit via MS_TIMEOUT_EN.
module ms_section_master
  import ms_section_types::*;
#(
  parameter int DATA_W      = 32,
  parameter int NUM_CH      = 2,
  parameter int INIT_VAL    = INIT_VAL_DEF,
  parameter int STEP        = STEP_DEF,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sync,
  output logic              in_notify,
  output logic [DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0] out_notify,
  input  logic [NUM_CH-1:0] out_sync,
  output logic [DATA_W-1:0] s_out,
  output logic [DATA_W-1:0] xfer_cnt,
  output logic              timeout_err
);

  localparam int CH_W = ch_width(NUM_CH);

  if (NUM_CH < 1) begin : g_bad_num_ch
    $error("NUM_CH must be at least 1");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  Sections           section_q, section_d;
  logic [DATA_W-1:0] val_q, val_d;
  logic [DATA_W-1:0] s_out_q, s_out_d;
  logic [DATA_W-1:0] xfer_cnt_q, xfer_cnt_d;
  logic [CH_W-1:0]   ch;
  logic              advance;

`ifdef MS_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              timeout_err_q, timeout_err_d;
`endif

  ms_rr_ptr #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_rr_ptr (
    .clk     (clk),
    .rst     (rst),
    .advance (advance),
    .ptr     (ch)
  );

  // A handshake always beats a simultaneous timeout, so it is tested first.
  always_comb begin
    section_d  = section_q;
    val_d      = val_q;
    s_out_d    = s_out_q;
    xfer_cnt_d = xfer_cnt_q;
    advance    = 1'b0;
`ifdef MS_TIMEOUT_EN
    wait_d        = wait_q;
    timeout_err_d = 1'b0;
`endif
    case (section_q)
      SECTION_A: begin
        if (in_sync) begin
          val_d = in_data;
        end
        section_d = SECTION_B;
`ifdef MS_TIMEOUT_EN
        wait_d = '0;
`endif
      end
      SECTION_B: begin
        if (out_sync[ch]) begin
          s_out_d    = val_q;
          val_d      = val_q + DATA_W'(STEP);
          xfer_cnt_d = xfer_cnt_q + DATA_W'(1);
          advance    = 1'b1;
          section_d  = SECTION_A;
        end
`ifdef MS_TIMEOUT_EN
        else if (wait_q == WAIT_W'(TIMEOUT_CYC - 1)) begin
          timeout_err_d = 1'b1;
          advance       = 1'b1;
          section_d     = SECTION_A;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
`endif
      end
      default: section_d = SECTION_A;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      section_q  <= SECTION_A;
      val_q      <= DATA_W'(INIT_VAL);
      s_out_q    <= '0;
      xfer_cnt_q <= '0;
    end else begin
      section_q  <= section_d;
      val_q      <= val_d;
      s_out_q    <= s_out_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

`ifdef MS_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_q        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wait_q        <= wait_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    out_notify = '0;
    if (section_q == SECTION_B) begin
      out_notify[ch] = 1'b1;
    end
  end

  assign in_notify = (section_q == SECTION_A);
  assign out_data  = val_q;
  assign s_out     = s_out_q;
  assign xfer_cnt  = xfer_cnt_q;

endmodule
